// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Boot loader that sits in front of the instruction memory. It receives a
// framed byte stream, assembles little-endian 32-bit words, writes them
// through the memory write port and holds the core in reset until a
// length-checked, checksum-verified image is in place.
//
// Frame layout:
//   LEN_LO, LEN_HI     16-bit word count N, little-endian
//   4*N payload bytes  word k, byte 0 first (bits [7:0])
//   1 checksum byte    XOR of all payload bytes (0x00 when N == 0)
//
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready
// are both high. byte_ready depends only on the current state and never on
// byte_valid. The sender may hold byte_valid low for any number of cycles;
// the loader then keeps its state and counters unchanged.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   load_start    one-cycle pulse; starts a load from IDLE, DONE or ERROR
//   byte_valid    byte_data is valid
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle
//   inst_wr_en    one-cycle write strobe (all byte lanes)
//   inst_wr_addr  word address of the write
//   inst_wr_data  word to write
//   core_reset_n  active-low reset to the core / PC
//   busy          high from LEN_LO through CHECK
//   done          high in DONE
//   error         high in ERROR
//   state_dbg     current FSM state encoding
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int INST_MEM_DEPTH = 2048,
    parameter int ADDR_WIDTH     = 9,
    parameter bit BOOT_HOLD      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  inst_wr_en,
    output logic [ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [31:0]           inst_wr_data,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Capacity in words, one bit wider than the length field so N up to
    // 65535 compares correctly against it.
    localparam logic [16:0] CAPACITY = 17'(INST_MEM_DEPTH / 4);

    state_t      state;
    state_t      state_next;

    logic        xfer;
    logic        start;
    logic [7:0]  len_lo;
    logic [15:0] len_full;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic [7:0]  checksum;
    logic        last_byte;

    assign xfer      = byte_valid & byte_ready;
    // load_start only matters in the resting states; while loading it is ignored.
    assign start     = load_start &
                       ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_full  = {byte_data, len_lo};
    // Fourth byte of the final word of the image.
    assign last_byte = (lane == 2'd3) && (word_idx == word_count - 16'd1);
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) begin
                    if (len_full == 16'd0)                 state_next = S_CHECK;
                    else if ({1'b0, len_full} > CAPACITY)  state_next = S_ERROR;
                    else                                   state_next = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && last_byte) state_next = S_CHECK;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) begin
                    state_next = (byte_data == checksum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (load_start) state_next = S_LEN_LO;
            end
            S_ERROR: begin
                error = 1'b1;
                if (load_start) state_next = S_LEN_LO;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: length capture, word assembly, checksum, write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_lo       <= '0;
            word_count   <= '0;
            word_idx     <= '0;
            lane         <= '0;
            word_buf     <= '0;
            checksum     <= '0;
            inst_wr_en   <= 1'b0;
            inst_wr_addr <= '0;
            inst_wr_data <= '0;
        end else begin
            inst_wr_en <= 1'b0;
            if (start) begin
                len_lo     <= '0;
                word_count <= '0;
                word_idx   <= '0;
                lane       <= '0;
                word_buf   <= '0;
                checksum   <= '0;
            end else if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo     <= byte_data;
                    S_LEN_HI: word_count <= len_full;
                    S_DATA: begin
                        checksum <= checksum ^ byte_data;
                        lane     <= lane + 2'd1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                // Write registers are separate from word_buf, so
                                // the next word can start assembling during the
                                // write cycle without disturbing it.
                                inst_wr_en   <= 1'b1;
                                inst_wr_addr <= word_idx[ADDR_WIDTH-1:0];
                                inst_wr_data <= {byte_data, word_buf};
                                word_idx     <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Core reset: dropped by any accepted load_start, released on entry to
    // DONE, and (without boot hold) released while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_n <= 1'b0;
        end else if (start) begin
            core_reset_n <= 1'b0;
        end else if (state_next == S_DONE) begin
            core_reset_n <= 1'b1;
        end else if ((state == S_IDLE) && !BOOT_HOLD) begin
            core_reset_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// Testbench for inst_mem_loader.
// The reference model works at frame level: from a frame's bytes it derives
// which byte transfers complete a word (and thus the write in the following
// cycle), the address and data of every write, and the final status (DONE
// or ERROR). A negedge monitor compares every DUT output against those
// expectations on every cycle.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int ADDR_WIDTH = 9;
    localparam int CAP        = 512;
    localparam int W          = ADDR_WIDTH + 32;

    // Clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // DUT signals
    logic                  load_start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  inst_wr_en;
    logic [ADDR_WIDTH-1:0] inst_wr_addr;
    logic [31:0]           inst_wr_data;
    logic                  core_reset_n;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [2:0]            state_dbg;

    inst_mem_loader #(
        .INST_MEM_DEPTH (2048),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BOOT_HOLD      (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    // Scoreboard state
    int             tests = 0;
    int             fails = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   wr_log[$];
    logic [W-1:0]   log_a[$];
    int             wr_count;
    logic [31:0]    mem [CAP];
    logic [7:0]     frame_q[$];

    // Per-cycle expectations, updated by the driver just after each edge
    logic exp_ready, exp_busy, exp_done, exp_err, exp_core, exp_wr_now;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / compare process
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        chk("byte_ready",   byte_ready,   exp_ready);
        chk("busy",         busy,         exp_busy);
        chk("done",         done,         exp_done);
        chk("error",        error,        exp_err);
        chk("core_reset_n", core_reset_n, exp_core);
        chk("inst_wr_en",   inst_wr_en,   exp_wr_now);
        if (inst_wr_en === 1'b1) begin
            wr_log.push_back({inst_wr_addr, inst_wr_data});
            wr_count++;
            mem[inst_wr_addr] = inst_wr_data;
            if (exp_wr_now) begin
                chk("wr_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("inst_wr_addr", inst_wr_addr, e[W-1:32]);
                    chk("inst_wr_data", inst_wr_data, e[31:0]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Model helpers
    // -------------------------------------------------------------------------
    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        for (int i = 2; i < frame_q.size() - 1; i++) x ^= frame_q[i];
        return x;
    endfunction

    task automatic build_frame(input int n, input bit good);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x ^= b;
        end
        if (good) frame_q.push_back(x);
        else      frame_q.push_back(x ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_wr_now = 1'b0;
    endtask

    // Drive one frame. gap_pct: probability of an idle cycle before each byte.
    // stop_after: send only that many bytes (-1 = whole frame).
    // ls_at: byte index that also carries a load_start pulse (-1 = none).
    task automatic run_frame(input int gap_pct, input int stop_after, input int ls_at);
        int         n;
        int         total;
        int         pidx;
        logic [7:0] x;
        n = {frame_q[1], frame_q[0]};
        total = (n > CAP) ? 2 : 2 + 4 * n + 1;
        if (stop_after >= 0 && stop_after < total) total = stop_after;
        // Byte offered in the load_start cycle must not be consumed.
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = frame_q[0];
        tick();
        load_start = 1'b0;
        exp_ready = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_core = 1'b0;
        x = 8'h00;
        for (int i = 0; i < total; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                tick();
            end
            byte_valid = 1'b1;
            byte_data  = frame_q[i];
            if (i == ls_at) load_start = 1'b1;
            tick();
            byte_valid = 1'b0;
            load_start = 1'b0;
            if (n <= CAP && i >= 2 && i < 2 + 4 * n) begin
                pidx = i - 2;
                x ^= frame_q[i];
                if (pidx % 4 == 3) begin
                    exp_wr_now = 1'b1;
                    exp_q.push_back({ADDR_WIDTH'(pidx / 4),
                                     frame_q[i], frame_q[i-1], frame_q[i-2], frame_q[i-3]});
                end
            end
            if (i == 2 + 4 * n + 1 - 1 || (n > CAP && i == 1)) begin
                exp_ready = 1'b0;
                exp_busy  = 1'b0;
                if (n <= CAP && frame_q[i] == x) begin
                    exp_done = 1'b1; exp_core = 1'b1;
                end else begin
                    exp_err = 1'b1;  exp_core = 1'b0;
                end
            end
        end
    endtask

    // Offer bytes while the loader rests; none may be accepted.
    task automatic offer_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Main stimulus
    // -------------------------------------------------------------------------
    initial begin
        reset_n    = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        exp_core  = 1'b0; exp_wr_now = 1'b0;
        wr_count  = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("rst_wr_addr", inst_wr_addr, 0);
        chk("rst_wr_data", inst_wr_data, 0);
        offer_idle(2);

        // Two-word image; payload XOR = 0x13 ^ 0x93 ^ 0x10 = 0x90
        frame_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        chk("model_xor_t1", model_xor(), 8'h90);
        wr_count = 0;
        run_frame(0, -1, -1);
        tick();
        chk("t1_writes", wr_count, 2);
        chk("t1_mem0", mem[0], 32'h0000_0013);
        chk("t1_mem1", mem[1], 32'h0010_0093);
        chk("t1_done", done, 1);
        chk("t1_core", core_reset_n, 1);
        offer_idle(3);

        // Bad checksum, then recovery with the good frame
        frame_q[10] = 8'h81;
        wr_count = 0;
        run_frame(0, -1, -1);
        tick();
        chk("t2_writes", wr_count, 2);
        chk("t2_error", error, 1);
        offer_idle(3);
        frame_q[10] = 8'h90;
        run_frame(20, -1, -1);
        tick();
        chk("t2_done", done, 1);

        // Oversized image: N = 513
        build_frame(513, 1'b1);
        wr_count = 0;
        run_frame(0, -1, -1);
        offer_idle(4);
        chk("t3_over_writes", wr_count, 0);
        chk("t3_over_error", error, 1);

        // Full-capacity image, word k = k
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h02);
        for (int k = 0; k < CAP; k++) begin
            frame_q.push_back(8'(k));
            frame_q.push_back(8'(k >> 8));
            frame_q.push_back(8'h00);
            frame_q.push_back(8'h00);
        end
        frame_q.push_back(8'h00);
        frame_q[frame_q.size() - 1] = model_xor();
        wr_count = 0;
        wr_log.delete();
        run_frame(0, -1, -1);
        tick();
        chk("t3_full_writes", wr_count, CAP);
        chk("t3_full_last", wr_log[wr_log.size() - 1], {9'd511, 32'd511});
        chk("t3_full_done", done, 1);

        // Same 3-word image at full rate and with random gaps
        build_frame(3, 1'b1);
        wr_log.delete();
        run_frame(0, -1, -1);
        tick();
        log_a = wr_log;
        wr_log.delete();
        run_frame(50, -1, -1);
        tick();
        chk("t4_count", wr_log.size(), 3);
        for (int k = 0; k < 3 && k < wr_log.size(); k++) chk("t4_same", wr_log[k], log_a[k]);

        // Empty images
        frame_q = {8'h00, 8'h00, 8'h00};
        wr_count = 0;
        run_frame(0, -1, -1);
        tick();
        chk("t5_empty_done", done, 1);
        frame_q = {8'h00, 8'h00, 8'h01};
        run_frame(10, -1, -1);
        tick();
        chk("t5_empty_err", error, 1);
        chk("t5_writes", wr_count, 0);

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            build_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)));
            run_frame($urandom_range(0, 50), -1, -1);
            offer_idle(2);
        end

        // Mid-load reset after 6 payload bytes
        frame_q = {8'h03, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde, 8'h11, 8'h22,
                   8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        wr_count = 0;
        run_frame(0, 8, -1);
        reset_n = 1'b0;
        exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_core = 1'b0;
        #1;
        chk("t6_rst_addr", inst_wr_addr, 0);
        chk("t6_rst_data", inst_wr_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        offer_idle(4);
        chk("t6_writes", wr_count, 1);
        chk("t6_q_empty", exp_q.size(), 0);

        // load_start while busy (mid-DATA) is ignored
        build_frame(4, 1'b1);
        run_frame(0, -1, 7);
        tick();
        chk("t6_busy_ls_done", done, 1);
        chk("t6_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
